// File: rtl/sid_mixer_pwm_pkg.sv
`default_nettype none
// ============================================================================
// Module  : sid_mixer_pwm_pkg
// Purpose : Shared widths and the mix/volume scaling helper for the SID
//           output stage (mixer, optional low-pass filter, PWM DAC).
// Ports   : none (package)
// Config  : none here; the filter option SID_MIXER_LPF_EN lives in
//           sid_mixer_pwm.
// Revision: 1.0 - initial release
// ============================================================================
package sid_mixer_pwm_pkg;

    localparam int SID_VOICE_W = 8;
    localparam int SID_PWM_W   = 8;
    localparam int SID_VOL_W   = 4;
    localparam int SID_FILT_W  = SID_PWM_W + 2;   // 8.2 fixed-point filter state

    // (a + b) * (vol + 1) >> 5. The largest product is 510 * 16 = 8160, which
    // fits in 13 bits, so after the shift the result always fits in 8 bits.
    function automatic logic [SID_PWM_W-1:0] mix_scale(
        input logic [SID_VOICE_W-1:0] a,
        input logic [SID_VOICE_W-1:0] b,
        input logic [SID_VOL_W-1:0]   vol
    );
        logic [SID_VOICE_W:0] sum;
        logic [13:0]          prod;
        sum  = {1'b0, a} + {1'b0, b};
        prod = {5'b0, sum} * {9'b0, ({1'b0, vol} + 5'd1)};
        return SID_PWM_W'(prod >> 5);
    endfunction

endpackage
`default_nettype wire

// File: rtl/sid_pwm_dac.sv
`default_nettype none
// ============================================================================
// Module  : sid_pwm_dac
// Purpose : 256-clock PWM frame generator. Holds the frame counter, the
//           per-frame duty register, the registered pin comparator and the
//           frame-start tick. A new duty is taken from 'sample' on the last
//           clock of each frame; 'load' flags that clock to the parent.
// Ports   : clk        in   system clock
//           rst_n      in   synchronous active-low reset
//           sample     in   duty value offered for the next frame
//           load       out  high in the cnt==255 cycle (duty latch edge)
//           pwm_out    out  registered PWM pin, high 'duty' clocks per frame
//           frame_tick out  one-cycle pulse in every cnt==0 cycle
//           duty       out  duty governing the current frame
// Revision: 1.0 - initial release
// ============================================================================
module sid_pwm_dac
    import sid_mixer_pwm_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [SID_PWM_W-1:0] sample,
    output logic                 load,
    output logic                 pwm_out,
    output logic                 frame_tick,
    output logic [SID_PWM_W-1:0] duty
);

    logic [SID_PWM_W-1:0] r_cnt;

    assign load = (r_cnt == {SID_PWM_W{1'b1}});

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_cnt      <= '0;
            duty       <= '0;
            pwm_out    <= 1'b0;
            frame_tick <= 1'b0;
        end else begin
            r_cnt      <= r_cnt + 1'b1;
            // The comparator sees the old duty on the latch edge, so the pin
            // is low in every cnt==0 cycle and high exactly 'duty' times.
            pwm_out    <= (r_cnt < duty);
            // Registered from the cnt==255 cycle so it lines up with cnt==0.
            frame_tick <= load;
            if (load) begin
                duty <= sample;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/sid_mixer_pwm.sv
`default_nettype none
// ============================================================================
// Module  : sid_mixer_pwm
// Purpose : SID output stage. Adds voice 1 and voice 2, scales by the master
//           volume ((vol+1)/32), registers the mix every clock and drives a
//           one-bit PWM DAC whose duty is refreshed once per 256-clock frame.
// Ports   : clk        in   system clock
//           rst_n      in   synchronous active-low reset
//           voice1     in   8-bit unsigned voice 1 sample
//           voice2     in   8-bit unsigned voice 2 sample
//           volume     in   4-bit master volume (0 = 1/16, 15 = full)
//           pwm_out    out  registered PWM DAC pin
//           frame_tick out  one-cycle pulse at the start of each frame
//           duty       out  duty of the current frame (observe only)
// Config  : SID_MIXER_LPF_EN - when defined, a one-pole IIR (10-bit, 8.2
//           fixed-point) smooths the mix before it becomes the frame duty.
//           When undefined the registered mix is used directly.
// Revision: 1.0 - initial release
// ============================================================================
module sid_mixer_pwm
    import sid_mixer_pwm_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [SID_VOICE_W-1:0] voice1,
    input  logic [SID_VOICE_W-1:0] voice2,
    input  logic [SID_VOL_W-1:0]   volume,
    output logic                   pwm_out,
    output logic                   frame_tick,
    output logic [SID_PWM_W-1:0]   duty
);

    logic [SID_PWM_W-1:0] w_mix;
    logic [SID_PWM_W-1:0] r_mix_q;
    logic [SID_PWM_W-1:0] w_sample;
    logic                 w_load;

    assign w_mix = mix_scale(voice1, voice2, volume);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_mix_q <= '0;
        end else begin
            r_mix_q <= w_mix;
        end
    end

`ifdef SID_MIXER_LPF_EN
    logic [SID_FILT_W-1:0]        r_filt;
    logic signed [SID_FILT_W:0]   w_err;
    logic signed [SID_FILT_W-1:0] w_step;
    logic [SID_FILT_W-1:0]        w_filt_next;

    // Error in 11-bit signed; the arithmetic shift floors, so a rising step
    // approaches the target from below and can never overshoot it.
    assign w_err       = $signed({1'b0, r_mix_q, 2'b00}) - $signed({1'b0, r_filt});
    // The filter stays within 0..1020, so the update is exact modulo 2^10.
    assign w_step      = SID_FILT_W'(w_err >>> 2);
    assign w_filt_next = r_filt + $unsigned(w_step);
    // Duty comes from the freshly updated state, not the previous one.
    assign w_sample    = w_filt_next[SID_FILT_W-1:2];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_filt <= '0;
        end else if (w_load) begin
            r_filt <= w_filt_next;
        end
    end
`else
    assign w_sample = r_mix_q;
`endif

    sid_pwm_dac u_dac (
        .clk        (clk),
        .rst_n      (rst_n),
        .sample     (w_sample),
        .load       (w_load),
        .pwm_out    (pwm_out),
        .frame_tick (frame_tick),
        .duty       (duty)
    );

endmodule
`default_nettype wire
